writeback_unit: RTL
===================

Name: writeback_unit

Overview:
- Writer side of the 32x64 integer register file: merges ALU results and load results onto the file's single write port (write-enable, destination address, write data).
- Also performs load data alignment and sign/zero extension, and arbitrates between the two producers with a starvation guard.
- Registers the write so the register file sees one clean write per cycle.
- Exports the in-flight write as a bypass so decode can forward around the one-cycle write latency.

Parameters:
- XLEN, 64, datapath width; must match register file width.
- STARVE_LIMIT, 4, consecutive cycles the ALU may lose arbitration before it is granted priority (1..15).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- alu_valid  input  1  ALU result present
- alu_ready  output  1  ALU result accepted this cycle
- alu_rd  input  5  ALU destination register
- alu_data  input  XLEN  ALU result
- mem_valid  input  1  load data present
- mem_ready  output  1  load data accepted this cycle
- mem_rd  input  5  load destination register
- mem_data  input  XLEN  raw 64-bit aligned doubleword from memory
- mem_size  input  2  0=byte, 1=half, 2=word, 3=double
- mem_unsigned  input  1  1=zero-extend, 0=sign-extend
- mem_byte_off  input  3  byte offset of access within doubleword
- rf_we  output  1  register file write enable
- rf_rd  output  5  register file destination address
- rf_wdata  output  XLEN  register file write data
- fwd_valid  output  1  bypass valid (equals rf_we)
- fwd_rd  output  5  bypass register (equals rf_rd)
- fwd_data  output  XLEN  bypass data (equals rf_wdata)
- alu_starved  output  1  starvation override active this cycle

Behaviour:
- Reset: rf_we=0, rf_rd=0, rf_wdata=0, starve counter=0, alu_starved=0.
  - Reset overrides any input handshake in the same cycle.
  - Reset mid-stream drops any result presented that cycle; no write is issued in the following cycle.
- Handshake: transfer occurs when valid&&ready at a rising edge. Ready is combinational from valid and the counter.
  - Exactly one source is granted per cycle; the unit never back-pressures the winner.
  - A producer must hold valid, rd and data stable until ready is seen.
- Arbitration:
  - Only one valid: that source is granted.
  - Both valid: MEM wins, unless the counter has reached STARVE_LIMIT; then ALU wins and alu_starved=1.
  - Counter: increments (saturating at STARVE_LIMIT) each cycle alu_valid=1 and alu_ready=0. It clears on any ALU grant, or when alu_valid=0.
- Load formatting (combinational, before the output register):
  - Lane = mem_byte_off with low bits forced to 0 for the access size: half clears bit0, word clears bits1:0, double uses lane 0.
  - Extract 8/16/32/64 bits from that lane, then sign- or zero-extend to XLEN. Double ignores mem_unsigned.
- Output stage, cycle N accepts -> cycle N+1 drives:
  - rf_we=1, rf_rd=granted rd, rf_wdata=granted/formatted data. The register file commits at the end of cycle N+1.
  - If no transfer occurs in cycle N, rf_we=0 in N+1; rf_rd and rf_wdata hold their previous values.
- x0: a transfer with rd=0 is accepted (ready asserted) but produces rf_we=0 and fwd_valid=0.
- Throughput: 1 write per cycle sustained; latency exactly 1 cycle from accept to rf_we.
- fwd_* mirror rf_* combinationally every cycle.

Test Plan:
- Reset asserted 2 cycles with alu_valid=1, alu_rd=5 -> alu_ready=0, rf_we=0 throughout and one cycle after deassertion; all rf_* outputs 0.
- ALU only: alu_rd=7, alu_data=0x1234 in cycle N -> alu_ready=1 in N; rf_we=1, rf_rd=7, rf_wdata=0x1234, fwd_valid=1 in N+1; rf_we=0 in N+2.
- Load formatting, mem_data=0x8877665544332211:
  - byte, off=7, signed -> 0xFFFFFFFFFFFFFF88
  - half, off=3 (aligned to 2), unsigned -> 0x0000000000004433
  - word, off=4, signed -> 0xFFFFFFFF88776655
  - double -> unchanged
- Contention, STARVE_LIMIT=4: both valid continuously with distinct rd -> MEM granted 4 cycles, ALU granted in cycle 5 with alu_starved=1, counter cleared, MEM granted in cycle 6.
- x0 write: mem_valid=1, mem_rd=0, mem_data=0xFF -> mem_ready=1; next cycle rf_we=0, fwd_valid=0.
- Back-to-back: alternate sources every cycle for 16 cycles -> 16 consecutive rf_we=1 cycles with matching rd/data order; no transfer lost or duplicated.

Source files
------------

// File: rtl/writeback_unit.sv
// Write-back stage: arbitrates ALU and load results onto the register file's
// single write port, formats load data, and exposes the registered write as a bypass.
module writeback_unit #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  input  logic [2:0]      mem_byte_off,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            alu_starved
);

  localparam int CW = 4;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0]   starveCnt_q, starveCnt_d;
  logic            we_q, we_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic            aluGrant, memGrant, starved;
  logic [2:0]      lane;
  logic [XLEN-1:0] shifted, loadData;

  // MEM normally wins a tie; the ALU takes over once it has lost LIMIT times in a row.
  always_comb begin
    aluGrant = 1'b0;
    memGrant = 1'b0;
    starved  = 1'b0;
    if (!reset) begin
      if (alu_valid && mem_valid) begin
        if (starveCnt_q >= LIMIT) begin
          aluGrant = 1'b1;
          starved  = 1'b1;
        end else begin
          memGrant = 1'b1;
        end
      end else if (alu_valid) begin
        aluGrant = 1'b1;
      end else if (mem_valid) begin
        memGrant = 1'b1;
      end
    end
  end

  assign alu_ready   = aluGrant;
  assign mem_ready   = memGrant;
  assign alu_starved = starved;

  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!alu_valid || aluGrant) begin
      starveCnt_d = '0;
    end else if (starveCnt_q < LIMIT) begin
      starveCnt_d = starveCnt_q + 1'b1;
    end
  end

  // Misaligned offsets are rounded down to the natural alignment of the access.
  always_comb begin
    case (mem_size)
      2'd0:    lane = mem_byte_off;
      2'd1:    lane = {mem_byte_off[2:1], 1'b0};
      2'd2:    lane = {mem_byte_off[2], 2'b00};
      default: lane = 3'd0;
    endcase
  end

  assign shifted = mem_data >> {lane, 3'b000};

  always_comb begin
    case (mem_size)
      2'd0: loadData = mem_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                    : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'd1: loadData = mem_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                    : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      2'd2: loadData = mem_unsigned ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                    : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      default: loadData = shifted;
    endcase
  end

  // Writes to x0 are consumed but never reach the register file or the bypass.
  always_comb begin
    we_d    = 1'b0;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    if (aluGrant && alu_rd != 5'd0) begin
      we_d    = 1'b1;
      rd_d    = alu_rd;
      wdata_d = alu_data;
    end else if (memGrant && mem_rd != 5'd0) begin
      we_d    = 1'b1;
      rd_d    = mem_rd;
      wdata_d = loadData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starveCnt_q <= '0;
      we_q        <= 1'b0;
      rd_q        <= 5'd0;
      wdata_q     <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
      we_q        <= we_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
    end
  end

  assign rf_we     = we_q;
  assign rf_rd     = rd_q;
  assign rf_wdata  = wdata_q;
  assign fwd_valid = we_q;
  assign fwd_rd    = rd_q;
  assign fwd_data  = wdata_q;

endmodule
